muldiv_ctrl: RTL

Sequencing stage directly upstream of the shared 33-bit `Multiplier` core, which runs shift-add multiply and shift-subtract divide. Accepts one RV32M operation (rs1, rs2, funct3) over a valid/ready handshake and prepares 33-bit operands for the core. It then drives `Run`/`div`, waits on `ready`, extracts and sign-corrects the 66-bit `{Aval,Bval}` result, and returns a 32-bit result with a one-cycle `resp_valid` pulse. Divide-by-zero and signed overflow bypass the core entirely.

---
 rtl/muldiv_ctrl_if.sv | 22 ++
 rtl/muldiv_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl_if.sv
// Request/response channel of the RV32M multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [2:0]      funct3;
  logic            resp_valid;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, rs1, rs2, funct3,
    input  req_ready, resp_valid, result
  );

  modport slave (
    input  req_valid, rs1, rs2, funct3,
    output req_ready, resp_valid, result
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer in front of the shared 33-bit shift-add/shift-subtract core.
// Prepares core operands, short-circuits divide corner cases and sign-corrects the core result.
module muldiv_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic          Clk,
  input  logic          Reset_n,
  muldiv_ctrl_if.slave  req,
  output logic          Run,
  output logic          div,
  output logic [XLEN:0] opA,
  output logic [XLEN:0] opB,
  input  logic          ready,
  input  logic [XLEN:0] Aval,
  input  logic [XLEN:0] Bval
);
  localparam int unsigned OPW = XLEN + 1;
  localparam int unsigned PW  = 2 * OPW;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic            first_q, first_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            run_d, div_d;
  logic [OPW-1:0]  opa_d, opb_d;
  logic            vld_q, vld_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            is_div_c, sgn_div_c, a_sgn_mul_c, b_sgn_mul_c, s1_c, s2_c;
  logic            rs2_zero_c, ovf_c, bypass_c;
  logic [XLEN-1:0] abs1_c, abs2_c, bypass_res_c;
  logic [OPW-1:0]  prep_a_c, prep_b_c;
  logic [XLEN-1:0] lo_c, hi_c, rem_c, fix_res_c;

  // Request decode: operand signedness, core operands and the divide short-circuit cases
  always_comb begin
    is_div_c    = req.funct3[2];
    sgn_div_c   = ~req.funct3[0];
    a_sgn_mul_c = (req.funct3[1:0] != 2'b11);
    b_sgn_mul_c = ~req.funct3[1];
    s1_c        = req.rs1[XLEN-1];
    s2_c        = req.rs2[XLEN-1];
    abs1_c      = (sgn_div_c && s1_c) ? (~req.rs1 + XLEN'(1)) : req.rs1;
    abs2_c      = (sgn_div_c && s2_c) ? (~req.rs2 + XLEN'(1)) : req.rs2;
    rs2_zero_c  = (req.rs2 == '0);
    ovf_c       = sgn_div_c && (req.rs1 == MIN_NEG) && (req.rs2 == '1);
    bypass_c    = is_div_c && (rs2_zero_c || ovf_c);
    if (rs2_zero_c) bypass_res_c = req.funct3[1] ? req.rs1 : '1;
    else            bypass_res_c = req.funct3[1] ? '0 : MIN_NEG;
    if (is_div_c) begin
      prep_a_c = {1'b0, abs1_c};
      prep_b_c = {1'b0, abs2_c};
    end else begin
      prep_a_c = {a_sgn_mul_c & s1_c, req.rs1};
      prep_b_c = {b_sgn_mul_c & s2_c, req.rs2};
    end
  end

  // Result selection: {Aval,Bval} is the product, or {remainder, quotient} for divides
  always_comb begin
    lo_c  = XLEN'(prod_q);
    hi_c  = XLEN'(prod_q >> XLEN);
    rem_c = XLEN'(prod_q >> OPW);
    if (!f3_q[2])     fix_res_c = (f3_q[1:0] == 2'b00) ? lo_c : hi_c;
    else if (f3_q[1]) fix_res_c = negr_q ? (~rem_c + XLEN'(1)) : rem_c;
    else              fix_res_c = negq_q ? (~lo_c + XLEN'(1)) : lo_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    first_d = first_q;
    prod_d  = prod_q;
    run_d   = 1'b0;
    div_d   = div;
    opa_d   = opA;
    opb_d   = opB;
    vld_d   = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid && ready) begin
          if (bypass_c) begin
            res_d   = bypass_res_c;
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            f3_d    = req.funct3;
            negq_d  = sgn_div_c & (s1_c ^ s2_c);
            negr_d  = sgn_div_c & s1_c;
            div_d   = is_div_c;
            opa_d   = prep_a_c;
            opb_d   = prep_b_c;
            run_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // The core is still lowering ready during the first wait cycle
        first_d = 1'b0;
        if (!first_q && ready) begin
          prod_d  = {Aval, Bval};
          state_d = FIX;
        end
      end
      FIX: begin
        res_d   = fix_res_c;
        vld_d   = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      f3_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      first_q <= 1'b0;
      prod_q  <= '0;
      Run     <= 1'b0;
      div     <= 1'b0;
      opA     <= '0;
      opB     <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      first_q <= first_d;
      prod_q  <= prod_d;
      Run     <= run_d;
      div     <= div_d;
      opA     <= opa_d;
      opB     <= opb_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
    end
  end

  assign req.req_ready  = (state_q == IDLE) && ready;
  assign req.resp_valid = vld_q;
  assign req.result     = res_q;
endmodule
